fir_coeff_ctrl: RTL and testbench

- Sequences coefficient loading into the folded FIR (fir) and gates filter operation until a complete coefficient set has been written.
- Accepts a valid/ready coefficient stream from the host/config side and drives the FIR c_WE/c_in/c_addr port with sequential addresses.
- Holds fir_en low until all (ORD+1)/2 coefficients are written and a settle interval has elapsed.
- Provides a stall watchdog and a status/error indication.

---
 rtl/fir_coeff_ctrl_pkg.sv | 26 ++
 rtl/fir_load_wdog.sv | 36 +++
 rtl/fir_coeff_ctrl.sv | 118 +++++++++++
 tb/tb_fir_coeff_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fir_coeff_ctrl_pkg.sv
// Shared definitions for the FIR coefficient controller.
// Holds the FSM state encoding, default filter sizing and the width helpers.
package fir_coeff_ctrl_pkg;

    localparam int FIR_ORD_DEF = 256;
    localparam int FIR_C_DEF   = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_RUN    = 3'd3,
        S_ERR    = 3'd4
    } fir_state_e;

    // A folded FIR stores only half of its symmetric taps.
    function automatic int fir_ncoef(input int ord);
        return (ord + 1) / 2;
    endfunction

    // Returns the number of bits needed to index n items, never less than one.
    function automatic int fir_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_load_wdog.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and flags expiry.
// A TIMEOUT of 0 disables the watchdog entirely.
module fir_load_wdog
    import fir_coeff_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int              WDW   = fir_width(TIMEOUT + 1);
    localparam bit              WD_ON = (TIMEOUT > 0);
    localparam logic [WDW-1:0]  LIMIT = WD_ON ? WDW'(TIMEOUT - 1) : WDW'(0);

    logic [WDW-1:0] cnt_r;

    // Idle counter; saturates at the limit so it never wraps while waiting.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (WD_ON && en && (cnt_r != LIMIT)) begin
            cnt_r <= cnt_r + WDW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = WD_ON && en && (cnt_r == LIMIT);

endmodule

// File: rtl/fir_coeff_ctrl.sv
// Loads a full coefficient set into the folded FIR and enables filtering
// only once every coefficient is written and a settle interval has passed.
module fir_coeff_ctrl
    import fir_coeff_ctrl_pkg::*;
#(
    parameter int ORD     = FIR_ORD_DEF,
    parameter int C       = FIR_C_DEF,
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                                     clk,
    input  logic                                     nrst,
    input  logic                                     start,
    input  logic                                     s_valid,
    input  logic [C-1:0]                             s_data,
    output logic                                     s_ready,
    output logic                                     c_WE,
    output logic [C-1:0]                             c_in,
    output logic [fir_width(fir_ncoef(ORD))-1:0]     c_addr,
    output logic                                     fir_en,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     err
);

    localparam int NCOEF = fir_ncoef(ORD);
    localparam int AW    = fir_width(NCOEF);
    localparam int WCW   = fir_width(NCOEF + 1);

    fir_state_e     state_r;
    logic [WCW-1:0] wcnt_r;
    logic [7:0]     scnt_r;
    logic           c_we_r;
    logic [C-1:0]   c_in_r;
    logic [AW-1:0]  c_addr_r;
    logic           done_r;
    logic           xfer_s;
    logic           wd_clr_s;
    logic           wd_en_s;
    logic           wd_expire_s;

    assign s_ready = (state_r == S_LOAD);
    assign busy    = (state_r == S_LOAD) || (state_r == S_SETTLE);
    assign fir_en  = (state_r == S_RUN);
    assign err     = (state_r == S_ERR);
    assign c_WE    = c_we_r;
    assign c_in    = c_in_r;
    assign c_addr  = c_addr_r;
    assign done    = done_r;

    assign xfer_s   = s_valid && s_ready;
    assign wd_en_s  = (state_r == S_LOAD);
    assign wd_clr_s = (state_r != S_LOAD) || xfer_s;

    fir_load_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .nrst   (nrst),
        .clr    (wd_clr_s),
        .en     (wd_en_s),
        .expire (wd_expire_s)
    );

    // Load sequencer: FIR write port, word counter, settle timer and state.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_r  <= S_IDLE;
            wcnt_r   <= '0;
            scnt_r   <= 8'd0;
            c_we_r   <= 1'b0;
            c_in_r   <= '0;
            c_addr_r <= '0;
            done_r   <= 1'b0;
        end else begin
            c_we_r <= xfer_s;
            done_r <= 1'b0;
            if (xfer_s) begin
                c_in_r   <= s_data;
                c_addr_r <= wcnt_r[AW-1:0];
            end
            case (state_r)
                S_IDLE, S_RUN, S_ERR: begin
                    if (start) begin
                        state_r <= S_LOAD;
                        wcnt_r  <= '0;
                    end
                end
                S_LOAD: begin
                    if (xfer_s) begin
                        wcnt_r <= wcnt_r + WCW'(1);
                        if (wcnt_r == WCW'(NCOEF - 1)) begin
                            state_r <= S_SETTLE;
                            scnt_r  <= 8'd0;
                        end
                    end else if (wd_expire_s) begin
                        state_r <= S_ERR;
                    end
                end
                // Settle timing starts only once the final write has landed.
                S_SETTLE: begin
                    if (c_we_r) begin
                        scnt_r <= 8'd0;
                    end else if (scnt_r == 8'(SETTLE - 1)) begin
                        state_r <= S_RUN;
                        done_r  <= 1'b1;
                    end else begin
                        scnt_r <= scnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Randomised self-checking bench for fir_coeff_ctrl against an event-level model.
module tb_fir_coeff_ctrl;

    localparam int ORD     = 8;
    localparam int C       = 16;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 8;
    localparam int NCOEF   = (ORD + 1) / 2;

    logic          clk;
    logic          nrst;
    logic          start;
    logic          s_valid;
    logic [C-1:0]  s_data;
    logic          s_ready;
    logic          c_WE;
    logic [C-1:0]  c_in;
    logic [1:0]    c_addr;
    logic          fir_en;
    logic          busy;
    logic          done;
    logic          err;

    int n_checks = 0;
    int n_errors = 0;

    // Model: plain flags, a coefficient count, an idle-cycle run length and
    // the absolute edge number at which filtering becomes enabled.
    bit           m_loading, m_settling, m_run, m_err, m_done, m_we;
    int           m_acc, m_idle, m_run_edge, edge_no;
    logic [C-1:0] m_cin;
    int           m_caddr;

    fir_coeff_ctrl #(
        .ORD     (ORD),
        .C       (C),
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk     (clk),
        .nrst    (nrst),
        .start   (start),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .c_WE    (c_WE),
        .c_in    (c_in),
        .c_addr  (c_addr),
        .fir_en  (fir_en),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s edge %0d got %0h expected %0h", tag, edge_no, got, exp);
        end
    endtask

    function automatic void model_step(input bit st, input bit v, input logic [C-1:0] d, input bit rn);
        edge_no++;
        m_done = 1'b0;
        m_we   = 1'b0;
        if (!rn) begin
            m_loading = 1'b0; m_settling = 1'b0; m_run = 1'b0; m_err = 1'b0;
            m_acc = 0; m_idle = 0; m_cin = '0; m_caddr = 0;
        end else if (m_loading) begin
            if (v) begin
                m_we    = 1'b1;
                m_cin   = d;
                m_caddr = m_acc;
                m_acc++;
                m_idle  = 0;
                if (m_acc == NCOEF) begin
                    // write lands the next cycle; fir_en low for SETTLE cycles after it
                    m_loading  = 1'b0;
                    m_settling = 1'b1;
                    m_run_edge = edge_no + 1 + SETTLE;
                end
            end else begin
                m_idle++;
                if (TIMEOUT > 0 && m_idle == TIMEOUT) begin
                    m_loading = 1'b0;
                    m_err     = 1'b1;
                end
            end
        end else if (m_settling) begin
            if (edge_no == m_run_edge) begin
                m_settling = 1'b0;
                m_run      = 1'b1;
                m_done     = 1'b1;
            end
        end else if (st) begin
            m_loading = 1'b1;
            m_acc = 0; m_idle = 0; m_err = 1'b0; m_run = 1'b0;
        end
    endfunction

    task automatic cyc(input bit st, input bit v, input logic [C-1:0] d, input bit rn);
        start = st; s_valid = v; s_data = d; nrst = rn;
        @(posedge clk);
        model_step(st, v, d, rn);
        #1;
        chk("s_ready", 32'(s_ready), 32'(m_loading));
        chk("c_WE",    32'(c_WE),    32'(m_we));
        chk("c_in",    32'(c_in),    32'(m_cin));
        chk("c_addr",  32'(c_addr),  32'(m_caddr));
        chk("fir_en",  32'(fir_en),  32'(m_run));
        chk("busy",    32'(busy),    32'(m_loading | m_settling));
        chk("done",    32'(done),    32'(m_done));
        chk("err",     32'(err),     32'(m_err));
    endtask

    function automatic logic [C-1:0] rnd();
        return C'($urandom);
    endfunction

    initial begin
        m_loading = 0; m_settling = 0; m_run = 0; m_err = 0; m_done = 0; m_we = 0;
        m_acc = 0; m_idle = 0; m_run_edge = 0; edge_no = 0; m_cin = '0; m_caddr = 0;
        start = 1'b0; s_valid = 1'b0; s_data = '0; nrst = 1'b0;

        // reset, then back-to-back load of the reference values
        repeat (2) cyc(1'b0, 1'b0, rnd(), 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1);
        cyc(1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < NCOEF; i++) cyc(1'b0, 1'b1, C'(16'h0011 * (i + 1)), 1'b1);
        repeat (10) cyc(1'b0, 1'b1, rnd(), 1'b1);

        // alternating valid; valid held high after the last transfer
        cyc(1'b1, 1'b0, rnd(), 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b0, (i % 2) == 0, rnd(), 1'b1);
        repeat (8) cyc(1'b0, 1'b1, rnd(), 1'b1);

        // watchdog expiry after two coefficients, then recovery
        cyc(1'b1, 1'b0, rnd(), 1'b1);
        repeat (2) cyc(1'b0, 1'b1, rnd(), 1'b1);
        repeat (11) cyc(1'b0, 1'b0, rnd(), 1'b1);
        cyc(1'b1, 1'b0, rnd(), 1'b1);
        repeat (NCOEF) cyc(1'b0, 1'b1, rnd(), 1'b1);
        repeat (8) cyc(1'b0, 1'b0, rnd(), 1'b1);

        // start held through LOAD and SETTLE, then a reload from RUN
        cyc(1'b1, 1'b0, rnd(), 1'b1);
        repeat (NCOEF) cyc(1'b1, 1'b1, rnd(), 1'b1);
        repeat (4) cyc(1'b1, 1'b0, rnd(), 1'b1);
        repeat (4) cyc(1'b0, 1'b0, rnd(), 1'b1);
        cyc(1'b1, 1'b0, rnd(), 1'b1);
        repeat (NCOEF) cyc(1'b0, 1'b1, rnd(), 1'b1);
        repeat (8) cyc(1'b0, 1'b0, rnd(), 1'b1);

        // reset mid-load, stream ignored until start, then a full load
        cyc(1'b1, 1'b0, rnd(), 1'b1);
        repeat (2) cyc(1'b0, 1'b1, rnd(), 1'b1);
        cyc(1'b0, 1'b1, rnd(), 1'b0);
        repeat (3) cyc(1'b0, 1'b1, rnd(), 1'b1);
        cyc(1'b1, 1'b0, rnd(), 1'b1);
        repeat (NCOEF) cyc(1'b0, 1'b1, rnd(), 1'b1);
        repeat (8) cyc(1'b0, 1'b0, rnd(), 1'b1);

        // transfer on the last idle cycle before expiry is accepted
        cyc(1'b1, 1'b0, rnd(), 1'b1);
        repeat (TIMEOUT - 1) cyc(1'b0, 1'b0, rnd(), 1'b1);
        cyc(1'b0, 1'b1, rnd(), 1'b1);
        repeat (TIMEOUT - 1) cyc(1'b0, 1'b0, rnd(), 1'b1);
        repeat (NCOEF - 1) cyc(1'b0, 1'b1, rnd(), 1'b1);
        repeat (8) cyc(1'b0, 1'b0, rnd(), 1'b1);

        // random soak
        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0, rnd(),
                $urandom_range(0, 149) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
